// File: rtl/pemul_pkg.sv
// rtl/pemul_pkg.sv - lane offset helpers, sum width and lane multiply function for pipelined_elementwise_multiplier
package pemul_pkg;

    // Widest operand lane_mul can handle; callers zero-pad narrower operands.
    localparam int MAX_N = 32;

    // Bit offset of lane `lane` inside a packed operand bus of n-bit lanes.
    function automatic int op_lo(input int lane, input int n);
        return lane * n;
    endfunction

    // Bit offset of lane `lane` inside a packed result bus of 2n-bit lanes.
    function automatic int res_lo(input int lane, input int n);
        return lane * 2 * n;
    endfunction

    // Width of the optional cross-lane sum: one product plus carry growth.
    function automatic int sum_w(input int n, input int lanes);
        return 2 * n + $clog2(lanes);
    endfunction

    // Product of the low n bits of a and b. Both operands are extended to the
    // full product width according to the mode, so the low 2n bits of the
    // wide product are the exact signed or unsigned result.
    function automatic logic [2*MAX_N-1:0] lane_mul(input logic [MAX_N-1:0] a,
                                                    input logic [MAX_N-1:0] b,
                                                    input logic is_signed,
                                                    input int n);
        logic [2*MAX_N-1:0] ext_mask;
        logic [2*MAX_N-1:0] ea;
        logic [2*MAX_N-1:0] eb;
        logic [MAX_N-1:0]   sa;
        logic [MAX_N-1:0]   sb;
        ext_mask = {(2*MAX_N){1'b1}} << n;
        sa = a >> (n - 1);
        sb = b >> (n - 1);
        ea = {{MAX_N{1'b0}}, a};
        eb = {{MAX_N{1'b0}}, b};
        if (is_signed && sa[0]) ea = ea | ext_mask;
        if (is_signed && sb[0]) eb = eb | ext_mask;
        return ea * eb;
    endfunction

endpackage

// File: rtl/pemul_lane.sv
// rtl/pemul_lane.sv - one multiplier lane: operand register, product and result pipeline (optional raw port under PEMUL_LANE_SUM_EN)
module pemul_lane
    import pemul_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic [STAGES-1:0] ld_valid,
    input  logic              mode,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
`ifdef PEMUL_LANE_SUM_EN
    output logic [2*N-1:0]    raw,
`endif
    output logic [2*N-1:0]    prod
);

    localparam int PR_N = (STAGES > 1) ? STAGES - 1 : 1;

    logic [N-1:0]                a_q;
    logic [N-1:0]                b_q;
    logic [2*N-1:0]              mul0;
    logic [PR_N-1:0][2*N-1:0]    pr;
    logic [STAGES-1:0][2*N-1:0]  src;

    // Stage 0: capture operands only for a valid incoming beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (adv && ld_valid[0]) begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign mul0 = (2*N)'(lane_mul(MAX_N'(a_q), MAX_N'(b_q), mode, N));

`ifdef PEMUL_LANE_SUM_EN
    assign raw = mul0;
`endif

    // src[k] is the value entering stage k+1; src[STAGES-1] is the lane output.
    always_comb begin
        src[0] = mul0;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = pr[k-1];
        end
    end

    // Product pipeline: each register loads only when its incoming beat is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr <= '0;
        end else begin
            for (int j = 0; j < STAGES - 1; j++) begin
                if (adv && ld_valid[j+1]) pr[j] <= src[j];
            end
        end
    end

    assign prod = src[STAGES-1];

endmodule

// File: rtl/pipelined_elementwise_multiplier.sv
// rtl/pipelined_elementwise_multiplier.sv - multi-lane pipelined multiplier with valid/ready handshake; PEMUL_LANE_SUM_EN adds out_sum
module pipelined_elementwise_multiplier
    import pemul_pkg::*;
#(
    parameter int N      = 8,
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_signed,
    input  logic [N*LANES-1:0]     in_a,
    input  logic [N*LANES-1:0]     in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*N*LANES-1:0]   out_result,
    output logic [CNT_W-1:0]       out_count
`ifdef PEMUL_LANE_SUM_EN
    ,
    output logic [2*N+$clog2(LANES)-1:0] out_sum
`endif
);

    logic              adv;
    logic              mode_q;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] ld_valid;

    // One global enable: the whole pipe moves unless a full output is stalled.
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign out_valid = v[STAGES-1];

    // ld_valid[k] is the valid bit arriving at stage k on the next advance.
    always_comb begin
        ld_valid[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            ld_valid[k] = v[k-1];
        end
    end

    // Valid chain: always shifts on advance, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else if (adv) begin
            v <= ld_valid;
        end
    end

    // Stage-0 mode bit travels with the operands; all lanes share it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else if (adv && in_valid) begin
            mode_q <= in_signed;
        end
    end

`ifdef PEMUL_LANE_SUM_EN
    localparam int SUM_W = sum_w(N, LANES);
    localparam int PR_N  = (STAGES > 1) ? STAGES - 1 : 1;
    logic [LANES*2*N-1:0]         raw_all;
    logic [STAGES-1:0][SUM_W-1:0] sum_src;
    logic [PR_N-1:0][SUM_W-1:0]   sum_pr;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int OL = op_lo(i, N);
        localparam int RL = res_lo(i, N);
        pemul_lane #(
            .N      (N),
            .STAGES (STAGES)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv      (adv),
            .ld_valid (ld_valid),
            .mode     (mode_q),
            .a        (in_a[OL +: N]),
            .b        (in_b[OL +: N]),
`ifdef PEMUL_LANE_SUM_EN
            .raw      (raw_all[RL +: 2*N]),
`endif
            .prod     (out_result[RL +: 2*N])
        );
    end

`ifdef PEMUL_LANE_SUM_EN
    // Cross-lane sum of the fresh products, extended per the beat's mode, then piped like a lane.
    always_comb begin
        sum_src[0] = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mode_q) sum_src[0] = sum_src[0] + SUM_W'($signed(raw_all[i*2*N +: 2*N]));
            else        sum_src[0] = sum_src[0] + SUM_W'(raw_all[i*2*N +: 2*N]);
        end
        for (int k = 1; k < STAGES; k++) begin
            sum_src[k] = sum_pr[k-1];
        end
    end

    // Sum pipeline registers, aligned with the lane product registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_pr <= '0;
        end else begin
            for (int j = 0; j < STAGES - 1; j++) begin
                if (adv && ld_valid[j+1]) sum_pr[j] <= sum_src[j];
            end
        end
    end

    assign out_sum = sum_src[STAGES-1];
`endif

    // Completed-beat counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipelined_elementwise_multiplier.sv
// tb/tb_pipelined_elementwise_multiplier.sv - directed self-checking bench for pipelined_elementwise_multiplier (PEMUL_LANE_SUM_EN aware)
module tb_pipelined_elementwise_multiplier;

    localparam int N      = 8;
    localparam int LANES  = 4;
    localparam int STAGES = 2;
    localparam int CNT_W  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [N*LANES-1:0]   in_a;
    logic [N*LANES-1:0]   in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*N*LANES-1:0] out_result;
    logic [CNT_W-1:0]     out_count;
`ifdef PEMUL_LANE_SUM_EN
    logic [2*N+$clog2(LANES)-1:0] out_sum;
`endif

    int compared   = 0;
    int mismatched = 0;

    pipelined_elementwise_multiplier #(
        .N      (N),
        .LANES  (LANES),
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
`ifdef PEMUL_LANE_SUM_EN
        .out_sum    (out_sum),
`endif
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          sent;
        int          recv;
        int          cyc;
        logic        stall;
        logic [63:0] held;
        logic [63:0] exp_r;
        logic [15:0] lane_v;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) step();

        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        // Unsigned beat then signed beat back-to-back.
        in_valid  = 1'b1;
        in_signed = 1'b0;
        in_a      = 32'h001002ff;
        in_b      = 32'h7f1003ff;
        #1;
        chk("u_accept_ready", in_ready, 1);
        step();
        in_signed = 1'b1;
        in_a      = 32'h817fff80;
        in_b      = 32'h7fff0180;
        chk("lat_t1_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        chk("u_t2_valid", out_valid, 1);
        chk("u_result", out_result, 64'h0000_0100_0006_fe01);
        step();
        chk("s_valid", out_valid, 1);
        chk("s_result", out_result, 64'hc0ff_ff81_ffff_4000);
        step();
        chk("drain_valid", out_valid, 0);
        chk("count_after_two", out_count, 2);

        // Reset asserted with two beats in flight.
        in_valid  = 1'b1;
        in_signed = 1'b0;
        in_a      = 32'h01010101;
        in_b      = 32'h01010101;
        step();
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_result", out_result, 0);
        chk("mid_rst_count", out_count, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_flush_valid", out_valid, 0);
        end
        chk("rst_flush_count", out_count, 0);

        // Back-pressure: 10 beats, sink stalled on cycles 3..7.
        sent = 0;
        recv = 0;
        cyc  = 0;
        held = '0;
        while (recv < 10 && cyc < 60) begin
            stall     = (cyc >= 3 && cyc <= 7);
            out_ready = !stall;
            in_valid  = (sent < 10);
            in_signed = ((sent % 2) == 1);
            in_a      = {4{8'(sent + 1)}};
            in_b      = {4{8'h02}};
            #1;
            if (stall) begin
                chk("bp_in_ready", in_ready, 0);
                if (cyc > 3) chk("bp_hold", out_result, held);
            end
            held = out_result;
            if (out_valid && out_ready) begin
                lane_v = 16'(2 * recv + 2);
                exp_r  = {4{lane_v}};
                chk("bp_order", out_result, exp_r);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_received", recv, 10);
        chk("bp_count", out_count, 10);

        // Continuous accept and complete: 7 beats on 7 consecutive cycles, count wraps 17 -> 1.
        for (int c = 0; c < 9; c++) begin
            in_valid  = (c < 7);
            in_signed = 1'b0;
            in_a      = {4{8'(c + 3)}};
            in_b      = {4{8'(c + 3)}};
            #1;
            if (c < 7) chk("tp_in_ready", in_ready, 1);
            if (c >= 2) begin
                lane_v = 16'((c + 1) * (c + 1));
                exp_r  = {4{lane_v}};
                chk("tp_valid", out_valid, 1);
                chk("tp_data", out_result, exp_r);
            end
            step();
        end
        in_valid = 1'b0;
        chk("tp_end_valid", out_valid, 0);
        chk("wrap_count", out_count, 1);

`ifdef PEMUL_LANE_SUM_EN
        in_valid  = 1'b1;
        in_signed = 1'b1;
        in_a      = 32'hffffffff;
        in_b      = 32'h01010101;
        step();
        in_valid = 1'b0;
        step();
        chk("sum_valid", out_valid, 1);
        chk("sum_result", out_result, 64'hffff_ffff_ffff_ffff);
        chk("sum_value", out_sum, 18'h3fffc);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
